// File: rtl/qspi_mem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : qspi_mem_adapter
// Purpose  : CPU memory port to byte-serial QSPI controller bridge.
//            Define QSPI_ADAPTER_CONTINUE_EN to keep sequential accesses open.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_mem_adapter #(
    parameter int ADDR_BITS    = 25,
    parameter int HOLD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [31:0]          data_in,
    input  logic [1:0]           data_size,
    input  logic                 read_req,
    input  logic                 write_req,
    output logic [31:0]          data_out,
    output logic                 data_ready,
    output logic                 write_done,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] q_addr,
    output logic [7:0]           q_data_in,
    output logic                 q_start_read,
    output logic                 q_start_write,
    output logic                 q_stall_txn,
    output logic                 q_stop_txn,
    input  logic [7:0]           q_data_out,
    input  logic                 q_data_req,
    input  logic                 q_data_ready,
    input  logic                 q_busy
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_WRITE = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;

    logic [2:0]           r_state;
    logic [ADDR_BITS-1:0] r_q_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rbuf;
    logic [31:0]          r_data_out;
    logic [1:0]           r_last;
    logic [1:0]           r_cnt;
    logic [7:0]           r_q_data_in;
    logic                 r_q_start_read;
    logic                 r_q_start_write;
    logic                 r_data_ready;
    logic                 r_write_done;

    logic                 w_launch;
    logic                 w_load;
    logic                 w_l_rd;
    logic [ADDR_BITS-1:0] w_l_addr;
    logic [1:0]           w_l_size;
    logic [31:0]          w_l_data;
    logic [2:0]           w_done_state;
    logic                 w_last_byte;
    logic [1:0]           w_cnt_inc;
    logic [31:0]          w_rbuf_next;

    // Index of the final byte lane: size 3 is treated as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    assign w_last_byte = (r_cnt == r_last);
    assign w_cnt_inc   = r_cnt + 2'd1;

    always_comb begin
        w_rbuf_next = r_rbuf;
        w_rbuf_next[{r_cnt, 3'b000} +: 8] = q_data_out;
    end

`ifdef QSPI_ADAPTER_CONTINUE_EN
    localparam logic [2:0] c_HOLD  = 3'd4;
    localparam int         c_TMR_W = $clog2(HOLD_TIMEOUT + 1);

    logic                 r_pend;
    logic                 r_pend_rd;
    logic                 r_dir_rd;
    logic [ADDR_BITS-1:0] r_pend_addr;
    logic [1:0]           r_pend_size;
    logic [31:0]          r_pend_data;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [ADDR_BITS-1:0] w_next_addr;
    logic                 w_req;
    logic                 w_resume;
    logic                 w_divert;
    logic                 w_expire;

    assign w_req        = read_req | write_req;
    assign w_next_addr  = r_q_addr + ADDR_BITS'({1'b0, r_last} + 3'd1);
    assign w_resume     = (r_state == c_HOLD) && w_req && (read_req == r_dir_rd)
                          && (addr_in == w_next_addr);
    assign w_divert     = (r_state == c_HOLD) && w_req && !w_resume;
    assign w_expire     = (r_state == c_HOLD) && !w_req
                          && (r_tmr == c_TMR_W'(HOLD_TIMEOUT - 1));
    // A request diverted out of HOLD is replayed from IDLE ahead of new traffic.
    assign w_launch     = (r_state == c_IDLE) && !q_busy && (r_pend || w_req);
    assign w_load       = w_launch || w_resume;
    assign w_l_rd       = r_pend ? r_pend_rd   : read_req;
    assign w_l_addr     = r_pend ? r_pend_addr : addr_in;
    assign w_l_size     = r_pend ? r_pend_size : data_size;
    assign w_l_data     = r_pend ? r_pend_data : data_in;
    assign w_done_state = c_HOLD;
    assign q_stall_txn  = (r_state == c_HOLD);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend      <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_dir_rd    <= 1'b0;
            r_pend_addr <= '0;
            r_pend_size <= 2'd0;
            r_pend_data <= 32'd0;
            r_tmr       <= '0;
        end else begin
            if ((r_state != c_HOLD) || w_req)
                r_tmr <= '0;
            else
                r_tmr <= r_tmr + c_TMR_W'(1);
            if (w_load)
                r_dir_rd <= w_l_rd;
            if (w_launch) begin
                r_pend <= 1'b0;
            end else if (w_divert) begin
                r_pend      <= 1'b1;
                r_pend_rd   <= read_req;
                r_pend_addr <= addr_in;
                r_pend_size <= data_size;
                r_pend_data <= data_in;
            end
        end
    end
`else
    assign w_launch     = (r_state == c_IDLE) && !q_busy && (read_req || write_req);
    assign w_load       = w_launch;
    assign w_l_rd       = read_req;
    assign w_l_addr     = addr_in;
    assign w_l_size     = data_size;
    assign w_l_data     = data_in;
    assign w_done_state = c_STOP;
    assign q_stall_txn  = 1'b0;

    // The hold timeout only matters when transactions may be held open.
    if (HOLD_TIMEOUT < 1) begin : g_no_hold_timer
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= c_IDLE;
            r_q_addr        <= '0;
            r_wdata         <= 32'd0;
            r_rbuf          <= 32'd0;
            r_data_out      <= 32'd0;
            r_last          <= 2'd0;
            r_cnt           <= 2'd0;
            r_q_data_in     <= 8'd0;
            r_q_start_read  <= 1'b0;
            r_q_start_write <= 1'b0;
            r_data_ready    <= 1'b0;
            r_write_done    <= 1'b0;
        end else begin
            r_q_start_read  <= 1'b0;
            r_q_start_write <= 1'b0;
            r_data_ready    <= 1'b0;
            r_write_done    <= 1'b0;
            if (w_load) begin
                r_q_addr        <= w_l_addr;
                r_last          <= last_idx(w_l_size);
                r_wdata         <= w_l_data;
                r_q_data_in     <= w_l_data[7:0];
                r_cnt           <= 2'd0;
                r_rbuf          <= 32'd0;
                r_state         <= w_l_rd ? c_READ : c_WRITE;
                r_q_start_read  <= w_launch & w_l_rd;
                r_q_start_write <= w_launch & ~w_l_rd;
            end else begin
                case (r_state)
                    c_READ: begin
                        if (q_data_ready) begin
                            r_rbuf <= w_rbuf_next;
                            if (w_last_byte) begin
                                r_data_out   <= w_rbuf_next;
                                r_data_ready <= 1'b1;
                                r_state      <= w_done_state;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    c_WRITE: begin
                        if (q_data_req) begin
                            if (w_last_byte) begin
                                r_write_done <= 1'b1;
                                r_state      <= w_done_state;
                            end else begin
                                r_cnt       <= w_cnt_inc;
                                r_q_data_in <= r_wdata[{w_cnt_inc, 3'b000} +: 8];
                            end
                        end
                    end
                    c_STOP: begin
                        if (!q_busy)
                            r_state <= c_IDLE;
                    end
`ifdef QSPI_ADAPTER_CONTINUE_EN
                    c_HOLD: begin
                        if (w_divert || w_expire)
                            r_state <= c_STOP;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Leaving STOP is visible as not-busy in the cycle q_busy=0 is sampled.
    assign busy          = (r_state == c_READ) || (r_state == c_WRITE)
                           || ((r_state == c_STOP) && q_busy);
    assign q_stop_txn    = (r_state == c_STOP);
    assign q_addr        = r_q_addr;
    assign q_data_in     = r_q_data_in;
    assign q_start_read  = r_q_start_read;
    assign q_start_write = r_q_start_write;
    assign data_out      = r_data_out;
    assign data_ready    = r_data_ready;
    assign write_done    = r_write_done;

endmodule
`default_nettype wire

// File: tb/tb_qspi_mem_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_mem_adapter
// Purpose  : Directed self-checking bench for qspi_mem_adapter (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_mem_adapter;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [24:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_size = '0;
    logic        read_req = 1'b0;
    logic        write_req = 1'b0;
    logic [31:0] data_out;
    logic        data_ready;
    logic        write_done;
    logic        busy;
    logic [24:0] q_addr;
    logic [7:0]  q_data_in;
    logic        q_start_read;
    logic        q_start_write;
    logic        q_stall_txn;
    logic        q_stop_txn;
    logic [7:0]  q_data_out = '0;
    logic        q_data_req = 1'b0;
    logic        q_data_ready = 1'b0;
    logic        q_busy = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    qspi_mem_adapter dut (
        .clk          (clk),
        .rstn         (rstn),
        .addr_in      (addr_in),
        .data_in      (data_in),
        .data_size    (data_size),
        .read_req     (read_req),
        .write_req    (write_req),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .write_done   (write_done),
        .busy         (busy),
        .q_addr       (q_addr),
        .q_data_in    (q_data_in),
        .q_start_read (q_start_read),
        .q_start_write(q_start_write),
        .q_stall_txn  (q_stall_txn),
        .q_stop_txn   (q_stop_txn),
        .q_data_out   (q_data_out),
        .q_data_req   (q_data_req),
        .q_data_ready (q_data_ready),
        .q_busy       (q_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 reading, 2 writing, 3 stopping.
    int          m = 0;
    int          need = 0;
    int          sent = 0;
    logic [31:0] wd = '0;
    logic [31:0] exp_dout = '0;
    logic [24:0] exp_qaddr = '0;
    logic        exp_sr = 1'b0, exp_sw = 1'b0, exp_rdy = 1'b0, exp_wd = 1'b0;
    logic [7:0]  got[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m = 0; need = 0; sent = 0; wd = '0; exp_dout = '0; exp_qaddr = '0;
            exp_sr = 1'b0; exp_sw = 1'b0; exp_rdy = 1'b0; exp_wd = 1'b0;
            got.delete();
        end else begin
            exp_sr = 1'b0; exp_sw = 1'b0; exp_rdy = 1'b0; exp_wd = 1'b0;
            case (m)
                0: if ((read_req || write_req) && !q_busy) begin
                    need = (data_size == 2'd0) ? 1 : (data_size == 2'd1) ? 2 : 4;
                    exp_qaddr = addr_in;
                    wd = data_in;
                    sent = 0;
                    got.delete();
                    if (read_req) begin m = 1; exp_sr = 1'b1; end
                    else begin m = 2; exp_sw = 1'b1; end
                end
                1: if (q_data_ready) begin
                    got.push_back(q_data_out);
                    if (got.size() == need) begin
                        exp_dout = '0;
                        foreach (got[i]) exp_dout = exp_dout + (32'(got[i]) << (8 * i));
                        exp_rdy = 1'b1;
                        m = 3;
                    end
                end
                2: if (q_data_req) begin
                    sent++;
                    if (sent == need) begin exp_wd = 1'b1; m = 3; end
                end
                3: if (!q_busy) m = 0;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_outputs", {data_out[15:0], q_addr[7:0], q_data_in},  32'd0);
            chk("rst_flags", 32'({data_ready, write_done, busy, q_start_read,
                                  q_start_write, q_stall_txn, q_stop_txn}), 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'((m == 1) || (m == 2) || ((m == 3) && q_busy)));
            chk("data_ready", 32'(data_ready), 32'(exp_rdy));
            chk("write_done", 32'(write_done), 32'(exp_wd));
            chk("q_start_read", 32'(q_start_read), 32'(exp_sr));
            chk("q_start_write", 32'(q_start_write), 32'(exp_sw));
            chk("q_stop_txn", 32'(q_stop_txn), 32'(m == 3));
            chk("q_stall_txn", 32'(q_stall_txn), 32'd0);
            chk("q_addr", 32'(q_addr), 32'(exp_qaddr));
            chk("data_out", data_out, exp_dout);
            if (m == 2) chk("q_data_in", 32'(q_data_in), 32'(8'(wd >> (8 * sent))));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic finish_stop();
        int t = 0;
        while (!q_stop_txn && t < 10) begin cyc(); t++; end
        chk("stop_seen", 32'(q_stop_txn), 32'd1);
        cyc(2);
        chk("stop_held", 32'(q_stop_txn), 32'd1);
        q_busy = 1'b0;
        #1;
        chk("busy_drop", 32'(busy), 32'd0);
        cyc();
        chk("stop_release", 32'(q_stop_txn), 32'd0);
    endtask

    task automatic do_read(input logic [24:0] a, input logic [1:0] sz,
                           input logic [31:0] bytes_le, input int n,
                           input logic [31:0] exp_word);
        addr_in = a; data_size = sz; read_req = 1'b1;
        cyc();
        read_req = 1'b0; write_req = 1'b0;
        chk("lit_start_read", 32'(q_start_read), 32'd1);
        chk("lit_q_addr", 32'(q_addr), 32'(a));
        q_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            q_data_out = bytes_le[8*i +: 8];
            q_data_ready = 1'b1;
            cyc();
            q_data_ready = 1'b0;
        end
        chk("lit_data_ready", 32'(data_ready), 32'd1);
        chk("lit_data_out", data_out, exp_word);
        finish_stop();
    endtask

    task automatic do_write(input logic [24:0] a, input logic [1:0] sz,
                            input logic [31:0] d, input int n,
                            input logic [31:0] exp_lanes);
        addr_in = a; data_size = sz; data_in = d; write_req = 1'b1;
        cyc();
        write_req = 1'b0;
        chk("lit_start_write", 32'(q_start_write), 32'd1);
        q_busy = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("lit_wbyte", 32'(q_data_in), 32'(exp_lanes[8*i +: 8]));
            q_data_req = 1'b1;
            cyc();
            q_data_req = 1'b0;
        end
        chk("lit_write_done", 32'(write_done), 32'd1);
        finish_stop();
    endtask

    initial begin
        #2 rstn = 1'b0;
        cyc(3);
        rstn = 1'b1;
        cyc(2);

        do_read(25'h000100, 2'd2, 32'h44332211, 4, 32'h44332211);
        cyc();
        do_write(25'h800010, 2'd1, 32'hAABBCCDD, 2, 32'h0000CCDD);
        chk("lit_no_bb", 32'(q_data_in), 32'h000000CC);
        cyc();
        do_read(25'h000007, 2'd0, 32'h000000F0, 1, 32'h000000F0);
        do_read(25'h1FFFFFE, 2'd1, 32'h0000A55A, 2, 32'h0000A55A);
        do_write(25'h000020, 2'd2, 32'h01020304, 4, 32'h01020304);
        do_read(25'h000040, 2'd3, 32'h8899AABB, 4, 32'h8899AABB);

        // Read and write together: read wins.
        write_req = 1'b1;
        data_in = 32'hDEADBEEF;
        do_read(25'h000050, 2'd0, 32'h0000005C, 1, 32'h0000005C);
        chk("lit_no_write_start", 32'(q_start_write), 32'd0);

        // Request while controller busy is ignored until it frees up.
        q_busy = 1'b1;
        addr_in = 25'h000060; data_size = 2'd0; read_req = 1'b1;
        cyc(3);
        chk("lit_ignored_busy", 32'({q_start_read, busy}), 32'd0);
        read_req = 1'b0; q_busy = 1'b0;
        cyc();

        // Stray controller strobes in IDLE.
        q_data_out = 8'h77; q_data_ready = 1'b1; q_data_req = 1'b1;
        cyc(2);
        q_data_ready = 1'b0; q_data_req = 1'b0;
        chk("lit_idle_ignore", data_out, 32'h0000005C);
        cyc();

        // Reset after two of four read bytes.
        addr_in = 25'h000080; data_size = 2'd2; read_req = 1'b1;
        cyc();
        read_req = 1'b0; q_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); q_data_out = 8'hE0 + 8'(i); q_data_ready = 1'b1;
            cyc(); q_data_ready = 1'b0;
        end
        rstn = 1'b0; q_busy = 1'b0;
        #1;
        chk("lit_rst_busy", 32'(busy), 32'd0);
        chk("lit_rst_data_out", data_out, 32'd0);
        chk("lit_rst_q_addr", 32'(q_addr), 32'd0);
        cyc(2);
        rstn = 1'b1;
        cyc();
        chk("lit_rst_no_ready", 32'(data_ready), 32'd0);
        do_read(25'h000084, 2'd2, 32'hCAFEF00D, 4, 32'hCAFEF00D);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/qspi_mem_adapter.md
Name: qspi_mem_adapter

Overview:
- Bridges the CPU-side memory port (32-bit, byte/half/word sized accesses) to the byte-serial QSPI controller interface.
- Issues transaction starts, streams write bytes on request, and assembles returned read bytes little-endian into a word.
- Ends each transaction with stop_txn.
- Sits directly upstream of qspi_controller; its q_* ports connect one-to-one to the controller's internal interface.

Parameters:
ADDR_BITS, 25, width of the byte address; bits [24:23] select flash/RAM A/RAM B inside the controller.
HOLD_TIMEOUT, 15, idle cycles a transaction is held open before stop (QSPI_ADAPTER_CONTINUE_EN only).

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
addr_in  input  ADDR_BITS  byte address of access
data_in  input  32  write data, little-endian, low bytes used for byte/half
data_size  input  2  0=byte, 1=half, 2=word; 3 is illegal
read_req  input  1  start read, sampled only when busy=0
write_req  input  1  start write, sampled only when busy=0
data_out  output  32  read result, valid with data_ready
data_ready  output  1  one-cycle pulse, read complete
write_done  output  1  one-cycle pulse, write complete
busy  output  1  adapter cannot accept a request
q_addr  output  ADDR_BITS  to controller addr_in
q_data_in  output  8  to controller data_in
q_start_read  output  1  to controller start_read
q_start_write  output  1  to controller start_write
q_stall_txn  output  1  to controller stall_txn
q_stop_txn  output  1  to controller stop_txn
q_data_out  input  8  from controller data_out
q_data_req  input  1  controller consumed q_data_in, wants next byte
q_data_ready  input  1  controller presents a read byte this cycle
q_busy  input  1  controller busy

Behaviour:
- Reset (async, rstn=0): state IDLE, byte count 0, data_out=0, every output 0. This includes q_addr and q_data_in. Mid-transaction reset abandons the access with no completion pulse; the controller shares rstn.
- States: IDLE, READ, WRITE, STOP (HOLD when the feature is enabled).
- busy=1 in every state except IDLE (and HOLD).
- IDLE:
  - Requests are accepted only when q_busy=0. A request made while q_busy=1 is ignored; upstream must hold or re-present it.
  - On accept: latch addr, size, and data_in. Set nbytes = 1/2/4. Drive q_addr and pulse q_start_read or q_start_write for exactly one cycle (the cycle after accept). Clear count.
  - read_req and write_req together: read wins, write is dropped.
  - data_size=3 is treated as word.
- READ:
  - On each q_data_ready, write q_data_out into data byte lane [count], then count++.
  - The upper lanes of data_out for byte/half accesses are zero; there is no sign extension.
  - On the final byte (count==nbytes-1): go to STOP and pulse data_ready in the following cycle with data_out stable. data_out holds until the next read completes.
- WRITE:
  - q_data_in = latched byte lane [count], valid from the q_start_write cycle onwards.
  - On q_data_req: count++ and q_data_in advances the next cycle.
  - On the final q_data_req: go to STOP and pulse write_done the next cycle.
- STOP: assert q_stop_txn continuously until q_busy=0 is sampled, then go to IDLE. The same-cycle return to IDLE makes busy=0.
- q_stall_txn=0 at all times unless the optional feature is enabled.
- q_data_ready/q_data_req arriving in IDLE or STOP are ignored.
- Count is 2 bits and never wraps past nbytes-1.

Optional Feature:
QSPI_ADAPTER_CONTINUE_EN:
- After the final byte, enter HOLD instead of STOP.
- HOLD asserts q_stall_txn, sets busy=0, and tracks next_addr = latched addr + nbytes (ADDR_BITS wrap).
- A request of the same direction with addr_in==next_addr resumes immediately: deassert stall, no q_start_*, and return to READ/WRITE with new size/data.
- Any other request, or HOLD_TIMEOUT cycles without a request, goes to STOP. A mismatched request is held internally and issued from IDLE after STOP.
- Without the macro: no HOLD state, q_stall_txn tied 0, every access is a full start/stop transaction.

Test Plan:
- Word read at addr 0x000100, controller returns 0x11,0x22,0x33,0x44 -> one q_start_read with q_addr=0x000100; data_ready pulse with data_out=0x44332211; q_stop_txn held until q_busy=0.
- Half write 0xAABBCCDD at 0x800010 -> q_start_write, q_data_in 0xDD then 0xCC on successive q_data_req; write_done once; 0xBB never driven.
- Byte read returning 0xF0 -> data_out=0x000000F0 (no sign extension); busy back to 0 the cycle q_busy=0 is sampled in STOP.
- read_req and write_req asserted together in IDLE -> only a read transaction starts; no write_done.
- Assert rstn=0 after 2 of 4 read bytes -> all outputs 0 immediately; no data_ready; the next read after reset completes normally.
- With QSPI_ADAPTER_CONTINUE_EN: word read 0x100 then word read 0x104 -> single q_start_read, q_stall_txn high between accesses, eight bytes total. A read at 0x200 instead -> STOP, then a new q_start_read at 0x200.
